// File: rtl/result_mem_ctrl_pkg.sv
// Shared types and default geometry for the result-memory capture controller.
package result_mem_ctrl_pkg;

    localparam int unsigned RM_WIDTH = 40;
    localparam int unsigned RM_DEPTH = 12;
    localparam int unsigned RM_LIMIT = 11;

    localparam int unsigned RM_ADDR_W = $clog2(RM_DEPTH);
    localparam int unsigned RM_CNT_W  = $clog2(RM_DEPTH + 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        FLUSH = 2'd2
    } rm_state_t;

endpackage

// File: rtl/result_mem_ctrl_rr_arbiter2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the one not served last.
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_en,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
                default: o_gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/result_mem_ctrl.sv
// Capture controller: arbitrates ALU/LFSR words into a sequentially filled result memory,
// flags completion at LIMIT words and flushes the array on clear.
module result_mem_ctrl
    import result_mem_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = RM_WIDTH,
    parameter int unsigned DEPTH = RM_DEPTH,
    parameter int unsigned LIMIT = RM_LIMIT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_clear,
    input  logic [1:0]                 i_req_valid,
    input  logic [WIDTH-1:0]           i_req_data0,
    input  logic [WIDTH-1:0]           i_req_data1,
    output logic [1:0]                 o_req_ready,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(LIMIT - 1);
    localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [AW:0]   DEPTH_A   = (AW + 1)'(DEPTH);

    rm_state_t        r_state;
    logic [CW-1:0]    r_ptr;
    logic [CW-1:0]    r_count;
    logic             r_last;
    logic             r_full;
    logic             r_done;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [1:0]       w_gnt;
    logic             w_en;
    logic             w_xfer;
    logic [WIDTH-1:0] w_wdata;

    // clear wins over any transfer in the same cycle
    assign w_en    = (r_state == FILL) && !i_clear;
    assign w_xfer  = |w_gnt;
    assign w_wdata = w_gnt[1] ? i_req_data1 : i_req_data0;

    rr_arbiter2 u_arb (
        .i_req  (i_req_valid),
        .i_en   (w_en),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FILL;
            r_ptr   <= '0;
            r_count <= '0;
            r_last  <= 1'b1;
            r_full  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                FILL: begin
                    if (i_clear) begin
                        r_state <= FLUSH;
                        r_ptr   <= '0;
                        r_count <= '0;
                    end else if (w_xfer) begin
                        r_mem[r_ptr[AW-1:0]] <= w_wdata;
                        r_ptr   <= r_ptr + ONE;
                        r_count <= r_count + ONE;
                        r_last  <= w_gnt[1];
                        if (r_count == LAST_CNT) begin
                            r_state <= FULL;
                            r_full  <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (i_clear) begin
                        r_state <= FLUSH;
                        r_ptr   <= '0;
                        r_count <= '0;
                        r_full  <= 1'b0;
                    end
                end
                FLUSH: begin
                    // r_ptr doubles as the flush index; it restarts at 0 for the next fill
                    r_mem[r_ptr[AW-1:0]] <= '0;
                    if (r_ptr == LAST_ADDR) begin
                        r_state <= FILL;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + ONE;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign o_req_ready = w_gnt;
    assign o_rd_data   = ({1'b0, i_rd_addr} < DEPTH_A) ? r_mem[i_rd_addr] : '0;
    assign o_count     = r_count;
    assign o_full      = r_full;
    assign o_done      = r_done;

endmodule
